// File: rtl/slow_mem_arbiter.sv
// Round-robin arbiter sharing one slow-memory-style backing store among NUM_CH
// cache ports, with a watchdog that aborts transactions the memory never answers.
module slow_mem_arbiter #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned ID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          c_read,
  input  logic [NUM_CH-1:0]          c_write,
  input  logic [NUM_CH*ADDR_W-1:0]   c_addr,
  input  logic [NUM_CH*DATA_W-1:0]   c_wdata,
  output logic [NUM_CH*DATA_W-1:0]   c_rdata,
  output logic [NUM_CH-1:0]          c_ready,
  output logic                       m_read,
  output logic                       m_write,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic                       m_ready,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                     state_q;
  logic [ID_W-1:0]            rr_q, grant_q;
  logic                       mask_vld_q;
  logic                       m_read_q, m_write_q;
  logic [ADDR_W-1:0]          m_addr_q;
  logic [DATA_W-1:0]          m_wdata_q;
  logic [NUM_CH*DATA_W-1:0]   c_rdata_q;
  logic [NUM_CH-1:0]          c_ready_q;
  logic [WD_W-1:0]            wd_q;
  logic                       timeout_err_q;

  logic [NUM_CH-1:0]          req;
  logic                       found;
  logic [ID_W-1:0]            win, rr_d;
  logic                       win_wr;
  logic [ADDR_W-1:0]          win_addr;
  logic [DATA_W-1:0]          win_wdata;

  // The channel served by the preceding RESP is masked for the first IDLE cycle.
  always_comb begin
    req = '0;
    for (int unsigned j = 0; j < NUM_CH; j++)
      req[j] = (c_read[j] | c_write[j]) & !(mask_vld_q && (grant_q == ID_W'(j)));
  end

  // Pass 0 covers channels at/above the rr pointer, pass 1 the wrapped remainder.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (!found && req[j] && ((p == 0) == (j >= 32'(rr_q)))) begin
          found     = 1'b1;
          win       = ID_W'(j);
          win_wr    = c_write[j];
          win_addr  = c_addr[j*ADDR_W +: ADDR_W];
          win_wdata = c_wdata[j*DATA_W +: DATA_W];
        end
      end
    end
    rr_d = (32'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      grant_q       <= '0;
      mask_vld_q    <= 1'b0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      c_rdata_q     <= '0;
      c_ready_q     <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      c_ready_q <= '0;
      case (state_q)
        IDLE: begin
          mask_vld_q <= 1'b0;
          if (found) begin
            grant_q   <= win;
            m_addr_q  <= win_addr;
            m_wdata_q <= win_wdata;
            m_write_q <= win_wr;
            m_read_q  <= !win_wr;
            rr_q      <= rr_d;
            wd_q      <= '0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ready) begin
            for (int unsigned j = 0; j < NUM_CH; j++) begin
              if (grant_q == ID_W'(j)) begin
                c_rdata_q[j*DATA_W +: DATA_W] <= m_rdata;
                c_ready_q[j]                  <= 1'b1;
              end
            end
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            state_q   <= RESP;
          end else if (TIMEOUT != 0 && wd_q == WD_W'(WD_LAST)) begin
            // Abort still completes the client handshake, with zeroed read data.
            for (int unsigned j = 0; j < NUM_CH; j++) begin
              if (grant_q == ID_W'(j)) begin
                c_rdata_q[j*DATA_W +: DATA_W] <= '0;
                c_ready_q[j]                  <= 1'b1;
              end
            end
            m_read_q      <= 1'b0;
            m_write_q     <= 1'b0;
            m_addr_q      <= '0;
            m_wdata_q     <= '0;
            timeout_err_q <= 1'b1;
            state_q       <= RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        RESP: begin
          mask_vld_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c_rdata     = c_rdata_q;
  assign c_ready     = c_ready_q;
  assign m_read      = m_read_q;
  assign m_write     = m_write_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_slow_mem_arbiter.sv
// Directed bench: a 2-channel arbiter (TIMEOUT=8) and a 4-channel arbiter on a shared clock/reset.
module tb_slow_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 2-channel instance
  logic [1:0]   a_read, a_write, a_ready;
  logic [55:0]  a_addr;
  logic [255:0] a_wdata, a_rdata;
  logic         am_read, am_write, am_ready;
  logic [27:0]  am_addr;
  logic [127:0] am_wdata, am_rdata;
  logic [0:0]   a_gid;
  logic         a_busy, a_terr;

  // 4-channel instance
  logic [3:0]   b_read, b_write, b_ready;
  logic [111:0] b_addr;
  logic [511:0] b_wdata, b_rdata;
  logic         bm_read, bm_write, bm_ready;
  logic [27:0]  bm_addr;
  logic [127:0] bm_wdata, bm_rdata;
  logic [1:0]   b_gid;
  logic         b_busy, b_terr;

  slow_mem_arbiter #(.NUM_CH(2), .ADDR_W(28), .DATA_W(128), .TIMEOUT(8), .ID_W(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .c_read(a_read), .c_write(a_write), .c_addr(a_addr), .c_wdata(a_wdata),
    .c_rdata(a_rdata), .c_ready(a_ready),
    .m_read(am_read), .m_write(am_write), .m_addr(am_addr), .m_wdata(am_wdata),
    .m_rdata(am_rdata), .m_ready(am_ready),
    .grant_id(a_gid), .busy(a_busy), .timeout_err(a_terr)
  );

  slow_mem_arbiter #(.NUM_CH(4), .ADDR_W(28), .DATA_W(128), .TIMEOUT(8), .ID_W(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .c_read(b_read), .c_write(b_write), .c_addr(b_addr), .c_wdata(b_wdata),
    .c_rdata(b_rdata), .c_ready(b_ready),
    .m_read(bm_read), .m_write(bm_write), .m_addr(bm_addr), .m_wdata(bm_wdata),
    .m_rdata(bm_rdata), .m_ready(bm_ready),
    .grant_id(b_gid), .busy(b_busy), .timeout_err(b_terr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] d1, d2, d3, d4, d5, w1;
  int           cnt;
  int           exp_g;
  logic [1:0]   exp_ra;
  logic [3:0]   exp_rb;

  initial begin
    d1 = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
    d2 = 128'h11112222_33334444_55556666_77778888;
    d3 = 128'hCAFEF00D_00000000_FFFFFFFF_12345678;
    d4 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    d5 = 128'h0BADC0DE_0BADC0DE_0BADC0DE_0BADC0DE;
    w1 = 128'h76543210_FEDCBA98_13579BDF_02468ACE;

    rst_n = 1'b0;
    a_read = '0; a_write = '0; a_addr = '0; a_wdata = '0; am_rdata = '0; am_ready = 1'b0;
    b_read = '0; b_write = '0; b_addr = '0; b_wdata = '0; bm_rdata = '0; bm_ready = 1'b0;
    tick();
    tick();
    check("rst_m_read", am_read, 0);
    check("rst_m_write", am_write, 0);
    check("rst_c_ready", a_ready, 0);
    check("rst_grant", a_gid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_terr", a_terr, 0);
    check("rst_c_rdata", a_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Single read, memory answers in the 5th ISSUE cycle
    a_read = 2'b01; a_addr[27:0] = 28'h0000010;
    tick();
    check("rd_m_read", am_read, 1);
    check("rd_m_write", am_write, 0);
    check("rd_m_addr", am_addr, 28'h10);
    check("rd_grant", a_gid, 0);
    check("rd_busy", a_busy, 1);
    cnt = 0;
    if (am_read) cnt++;
    repeat (4) begin
      tick();
      if (am_read) cnt++;
    end
    am_ready = 1'b1; am_rdata = d1;
    tick();
    am_ready = 1'b0; am_rdata = '0;
    if (am_read) cnt++;
    check("rd_m_read_cycles", cnt, 5);
    check("rd_c_ready", a_ready, 2'b01);
    check("rd_c_rdata", a_rdata[127:0], d1);
    check("rd_busy_resp", a_busy, 1);
    a_read = '0;
    tick();
    check("rd_ready_drop", a_ready, 0);
    check("rd_idle", a_busy, 0);
    check("rd_rdata_held", a_rdata[127:0], d1);

    // Contention: rr pointer is at 1 after the single read, so grants go 1,0,1,0
    tick();
    a_addr = {28'h200, 28'h100}; a_read = 2'b11; am_ready = 1'b1; am_rdata = d2;
    for (int k = 0; k < 4; k++) begin
      exp_g  = (k % 2 == 0) ? 1 : 0;
      exp_ra = (exp_g == 1) ? 2'b10 : 2'b01;
      tick();
      check("cont_grant", a_gid, exp_g);
      check("cont_addr", am_addr, (exp_g == 1) ? 28'h200 : 28'h100);
      tick();
      check("cont_ready", a_ready, exp_ra);
      check("cont_rdata", a_rdata[exp_g*128 +: 128], d2);
      if (k == 3) a_read = '0;
      tick();
      check("cont_ready_drop", a_ready, 0);
    end
    am_ready = 1'b0;

    // Read+write on ch1 is a write; operand changes mid-ISSUE are ignored
    tick();
    a_read = 2'b10; a_write = 2'b10; a_addr[55:28] = 28'hABC;
    a_wdata[255:128] = w1; a_wdata[127:0] = d3;
    tick();
    check("wr_m_write", am_write, 1);
    check("wr_m_read", am_read, 0);
    check("wr_m_addr", am_addr, 28'hABC);
    check("wr_m_wdata", am_wdata, w1);
    check("wr_grant", a_gid, 1);
    a_addr[55:28] = 28'hFFF; a_wdata[255:128] = '0;
    tick();
    check("wr_addr_stable", am_addr, 28'hABC);
    check("wr_wdata_stable", am_wdata, w1);
    am_ready = 1'b1;
    tick();
    am_ready = 1'b0;
    check("wr_c_ready", a_ready, 2'b10);
    check("wr_m_write_drop", am_write, 0);
    a_read = '0; a_write = '0;
    tick();
    check("wr_ready_drop", a_ready, 0);

    // Held request: the just-served channel sits out one IDLE cycle
    tick();
    a_read = 2'b01; a_addr[27:0] = 28'h20; am_ready = 1'b1; am_rdata = d3;
    tick();
    check("mask_grant", a_gid, 0);
    tick();
    check("mask_ready", a_ready, 2'b01);
    check("mask_rdata", a_rdata[127:0], d3);
    tick();
    check("mask_idle1", a_busy, 0);
    tick();
    check("mask_idle2", a_busy, 0);
    check("mask_no_issue", am_read, 0);
    tick();
    check("mask_regrant", a_busy, 1);
    check("mask_m_read", am_read, 1);
    a_read = '0;
    tick();
    check("mask_ready2", a_ready, 2'b01);
    tick();
    am_ready = 1'b0;

    // Watchdog: memory never answers
    tick();
    a_read = 2'b01; a_addr[27:0] = 28'h55;
    tick();
    check("wd_m_read", am_read, 1);
    cnt = 0;
    repeat (8) begin
      if (am_read) cnt++;
      tick();
    end
    check("wd_issue_cycles", cnt, 8);
    check("wd_m_read_drop", am_read, 0);
    check("wd_m_addr_drop", am_addr, 0);
    check("wd_c_ready", a_ready, 2'b01);
    check("wd_c_rdata", a_rdata[127:0], 0);
    check("wd_terr", a_terr, 1);
    a_read = '0;
    tick();
    check("wd_ready_drop", a_ready, 0);
    check("wd_terr_sticky", a_terr, 1);
    tick();
    check("wd_terr_sticky2", a_terr, 1);

    // Reset in the middle of ISSUE, then the held request retries
    tick();
    a_read = 2'b10; a_addr[55:28] = 28'h77;
    tick();
    check("rs_m_read", am_read, 1);
    check("rs_grant", a_gid, 1);
    tick();
    rst_n = 1'b0;
    tick();
    check("rs_m_read0", am_read, 0);
    check("rs_m_addr0", am_addr, 0);
    check("rs_grant0", a_gid, 0);
    check("rs_busy0", a_busy, 0);
    check("rs_terr0", a_terr, 0);
    check("rs_c_ready0", a_ready, 0);
    check("rs_c_rdata0", a_rdata, 0);
    check("rs_b_grant0", b_gid, 0);
    check("rs_b_busy0", b_busy, 0);
    rst_n = 1'b1;
    tick();
    check("rs_retry_m_read", am_read, 1);
    check("rs_retry_addr", am_addr, 28'h77);
    check("rs_retry_grant", a_gid, 1);
    check("rs_no_ready", a_ready, 0);
    am_ready = 1'b1; am_rdata = d4;
    tick();
    am_ready = 1'b0;
    check("rs_retry_ready", a_ready, 2'b10);
    check("rs_retry_rdata", a_rdata[255:128], d4);
    a_read = '0;
    tick();
    check("rs_ready_drop", a_ready, 0);

    // 4 channels all requesting: grants 0,1,2,3,0
    tick();
    b_read = 4'hF; b_addr = {28'h1003, 28'h1002, 28'h1001, 28'h1000};
    bm_ready = 1'b1; bm_rdata = d5;
    for (int k = 0; k < 5; k++) begin
      exp_g  = k % 4;
      exp_rb = 4'b0001 << exp_g;
      tick();
      check("b_grant", b_gid, exp_g);
      check("b_addr", bm_addr, 28'h1000 + exp_g);
      tick();
      check("b_ready", b_ready, exp_rb);
      check("b_rdata", b_rdata[exp_g*128 +: 128], d5);
      if (k == 4) b_read = '0;
      tick();
      check("b_ready_drop", b_ready, 0);
    end
    bm_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
